// File: rtl/port_sweep_checker_pkg.sv
// Shared types for the operand port-sweep checker.
// State encoding and the default MISR feedback polynomial.
package port_sweep_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLING,
      CAPTURE,
      DONE
   } state_t;

   localparam logic [31:0] DEF_POLY = 32'h04C11DB7;

endpackage

// File: rtl/port_sweep_checker_if.sv
// Operand/result bus between the sweep checker and the device under test.
// The checker drives in1/in2 and observes the flattened result bank.
interface port_sweep_if #(
   parameter int WIDTH = 4,
   parameter int NOUT  = 59
);

   logic [WIDTH-1:0]      in1;
   logic [WIDTH-1:0]      in2;
   logic [NOUT*WIDTH-1:0] resp;

   modport master (
      output in1,
      output in2,
      input  resp
   );

   modport slave (
      input  in1,
      input  in2,
      output resp
   );

endinterface

// File: rtl/port_sweep_checker_misr32.sv
// 32-bit MISR over the flattened result bank.
// The bank is zero-padded to whole 32-bit slices and XOR-folded per capture.
module misr32
   import port_sweep_pkg::*;
#(
   parameter int          WIDTH = 4,
   parameter int          NOUT  = 59,
   parameter logic [31:0] POLY  = DEF_POLY
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  en,
   input  logic [NOUT*WIDTH-1:0] resp,
   output logic [31:0]           sig,
   output logic [31:0]           sig_next
);

   localparam int RW  = NOUT * WIDTH;
   localparam int NSL = (RW + 31) / 32;

   logic [NSL*32-1:0] padded;
   logic [31:0]       fold;

   always_comb begin
      padded         = '0;
      padded[RW-1:0] = resp;
      fold           = '0;
      for (int i = 0; i < NSL; i++) begin
         fold = fold ^ padded[i*32 +: 32];
      end
   end

   assign sig_next = {sig[30:0], 1'b0}
                   ^ (sig[31] ? POLY : 32'h0)
                   ^ fold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sig <= '0;
      end else if (clr) begin
         sig <= '0;
      end else if (en) begin
         sig <= sig_next;
      end
   end

endmodule

// File: rtl/port_sweep_checker.sv
// Sweeps every (in1, in2) operand pair into the DUT and signs its results.
// Each vector is DRIVE, SETTLE cycles of settling, then one CAPTURE.
module port_sweep_checker
   import port_sweep_pkg::*;
#(
   parameter int          WIDTH  = 4,
   parameter int          NOUT   = 59,
   parameter int          SETTLE = 1,
   parameter logic [31:0] POLY   = DEF_POLY
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      exp_sig,
   port_sweep_if.master     bus,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [31:0]      sig,
   output logic [2*WIDTH:0] vec_cnt
);

   localparam int             VW    = 2 * WIDTH;
   localparam logic [VW-1:0]  VLAST = '1;
   localparam logic [3:0]     SLAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);

   state_t            state;
   state_t            state_nx;
   logic [VW-1:0]     v;
   logic [3:0]        scnt;
   logic [WIDTH-1:0]  in1_q;
   logic [WIDTH-1:0]  in2_q;
   logic [VW:0]       cnt_q;
   logic              pass_q;
   logic              go;
   logic              cap;
   logic              last;
   logic [31:0]       sig_next;

   assign go   = start && (state == IDLE || state == DONE);
   assign cap  = (state == CAPTURE);
   assign last = (v == VLAST);

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE, DONE: begin
            if (start) state_nx = DRIVE;
         end
         DRIVE: begin
            state_nx = (SETTLE > 0) ? SETTLING : CAPTURE;
         end
         SETTLING: begin
            if (scnt == SLAST) state_nx = CAPTURE;
         end
         CAPTURE: begin
            state_nx = last ? DONE : DRIVE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         v      <= '0;
         scnt   <= '0;
         in1_q  <= '0;
         in2_q  <= '0;
         cnt_q  <= '0;
         pass_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (go) begin
            v      <= '0;
            scnt   <= '0;
            cnt_q  <= '0;
            pass_q <= 1'b0;
         end else begin
            unique case (state)
               DRIVE: begin
                  in1_q <= v[WIDTH-1:0];
                  in2_q <= v[VW-1:WIDTH];
                  scnt  <= '0;
               end
               SETTLING: scnt <= scnt + 4'd1;
               CAPTURE: begin
                  cnt_q <= cnt_q + (VW+1)'(1);
                  // pass reflects the signature that DONE will show
                  if (last) pass_q <= (sig_next == exp_sig);
                  else      v      <= v + VW'(1);
               end
               default: ;
            endcase
         end
      end
   end

   misr32 #(
      .WIDTH (WIDTH),
      .NOUT  (NOUT),
      .POLY  (POLY)
   ) u_misr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (go),
      .en       (cap),
      .resp     (bus.resp),
      .sig      (sig),
      .sig_next (sig_next)
   );

   assign bus.in1 = in1_q;
   assign bus.in2 = in2_q;
   assign busy    = (state == DRIVE) || (state == SETTLING)
                 || (state == CAPTURE);
   assign done    = (state == DONE);
   assign pass    = pass_q;
   assign vec_cnt = cnt_q;

endmodule

// File: tb/tb_port_sweep_checker.sv
// Bench for port_sweep_checker: two instances (SETTLE=1 and SETTLE=0)
// against a vector-level model of the sweep timeline and signature.
module tb_port_sweep_checker;
   import port_sweep_pkg::*;

   localparam int W  = 4;
   localparam int NO = 59;
   localparam int RW = NO * W;
   localparam logic [31:0] MPOLY = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] exp_sig;
   int          mode;
   logic [RW-1:0] rtab [256];

   always #5 clk = ~clk;

   port_sweep_if #(.WIDTH(W), .NOUT(NO)) bus0 ();
   port_sweep_if #(.WIDTH(W), .NOUT(NO)) bus1 ();

   logic        d_busy [2];
   logic        d_done [2];
   logic        d_pass [2];
   logic [31:0] d_sig  [2];
   logic [8:0]  d_cnt  [2];
   logic [7:0]  d_in   [2];

   port_sweep_checker #(.WIDTH(W), .NOUT(NO), .SETTLE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .exp_sig(exp_sig),
      .bus(bus0), .busy(d_busy[0]), .done(d_done[0]),
      .pass(d_pass[0]), .sig(d_sig[0]), .vec_cnt(d_cnt[0])
   );

   port_sweep_checker #(.WIDTH(W), .NOUT(NO), .SETTLE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start), .exp_sig(exp_sig),
      .bus(bus1), .busy(d_busy[1]), .done(d_done[1]),
      .pass(d_pass[1]), .sig(d_sig[1]), .vec_cnt(d_cnt[1])
   );

   assign d_in[0] = {bus0.in2, bus0.in1};
   assign d_in[1] = {bus1.in2, bus1.in1};

   // Reference DUT: mode 0 zeros, 1 bit0 only, 2 port logic,
   // 3 port logic with bout3 bit flipped at vector 0x5A, 4 random table
   function automatic logic [RW-1:0] resp_of(int md, logic [7:0] vec);
      logic [RW-1:0] r;
      logic [3:0] a;
      logic [3:0] b;
      r = '0;
      a = vec[3:0];
      b = vec[7:4];
      if (md == 1) r[0] = 1'b1;
      if (md == 2 || md == 3) begin
         for (int k = 0; k < NO; k++)
            r[k*4 +: 4] = 4'(a * (k % 5 + 1)) + (b ^ 4'(k));
         if (md == 3 && vec == 8'h5A) r[13*4] = ~r[13*4];
      end
      return r;
   endfunction

   always_comb bus0.resp = (mode == 4) ? rtab[d_in[0]] : resp_of(mode, d_in[0]);
   always_comb bus1.resp = (mode == 4) ? rtab[d_in[1]] : resp_of(mode, d_in[1]);

   function automatic logic [RW-1:0] model_resp(int md, int vi);
      return (md == 4) ? rtab[vi] : resp_of(md, 8'(vi));
   endfunction

   function automatic logic [31:0] fold(logic [RW-1:0] r);
      logic [255:0] p;
      logic [31:0] f;
      p = 256'(r);
      f = '0;
      for (int i = 0; i < 8; i++) f = f ^ p[i*32 +: 32];
      return f;
   endfunction

   function automatic logic [31:0] step(logic [31:0] s, logic [RW-1:0] r);
      return {s[30:0], 1'b0} ^ (s[31] ? MPOLY : 32'h0) ^ fold(r);
   endfunction

   function automatic logic [31:0] sweep_sig(int md);
      logic [31:0] s;
      s = '0;
      for (int k = 0; k < 256; k++) s = step(s, model_resp(md, k));
      return s;
   endfunction

   int errors = 0;
   int checks = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Model: cycles since the accepted start, and signature prefixes
   logic [31:0] pre [2][257];
   bit          mact  [2];
   int          mc    [2];
   bit          mpass [2];
   logic [7:0]  min0  [2];
   bit          mvalid = 0;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         mvalid = 1;
         for (int i = 0; i < 2; i++) begin
            mact[i] = 0; mc[i] = 0; mpass[i] = 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            int n;
            n = 256 * (i == 1 ? 3 : 2);
            if (start && (!mact[i] || mc[i] >= n)) begin
               min0[i]  = mact[i] ? 8'hFF : 8'h00;
               mact[i]  = 1;
               mc[i]    = 0;
               mpass[i] = 0;
               pre[i][0] = '0;
               for (int k = 0; k < 256; k++)
                  pre[i][k+1] = step(pre[i][k], model_resp(mode, k));
            end else if (mact[i] && mc[i] < n) begin
               mc[i]++;
               if (mc[i] == n) mpass[i] = (pre[i][256] == exp_sig);
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (mvalid) begin
         for (int i = 0; i < 2; i++) begin
            int p, n, k, ph;
            logic eb, ed, ep;
            logic [31:0] es;
            logic [8:0] ec;
            logic [7:0] ei;
            p = (i == 1) ? 3 : 2;
            n = 256 * p;
            if (!mact[i]) begin
               eb = 0; ed = 0; ep = 0; es = '0; ec = '0; ei = '0;
            end else if (mc[i] < n) begin
               k  = mc[i] / p;
               ph = mc[i] % p;
               eb = 1; ed = 0; ep = 0;
               es = pre[i][k];
               ec = 9'(k);
               if (ph != 0)    ei = 8'(k);
               else if (k > 0) ei = 8'(k - 1);
               else            ei = min0[i];
            end else begin
               eb = 0; ed = 1; ep = mpass[i];
               es = pre[i][256]; ec = 9'd256; ei = 8'hFF;
            end
            chk($sformatf("u%0d.busy", i), 32'(d_busy[i]), 32'(eb));
            chk($sformatf("u%0d.done", i), 32'(d_done[i]), 32'(ed));
            chk($sformatf("u%0d.pass", i), 32'(d_pass[i]), 32'(ep));
            chk($sformatf("u%0d.sig", i), d_sig[i], es);
            chk($sformatf("u%0d.vec_cnt", i), 32'(d_cnt[i]), 32'(ec));
            chk($sformatf("u%0d.in", i), 32'(d_in[i]), 32'(ei));
         end
      end
   end

   logic [7:0]  hist_in   [800];
   logic [31:0] hist_sig  [800];
   logic        hist_done [800];
   int b0, b1;

   task automatic run_sweep(input bit extra, input int at);
      bit ok;
      ok = 0;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      b0 = 0; b1 = 0;
      for (int n = 0; n < 3000; n++) begin
         if (n < 800) begin
            hist_in[n]   = d_in[1];
            hist_sig[n]  = d_sig[1];
            hist_done[n] = d_done[1];
         end
         if (d_busy[1]) b1++;
         if (d_busy[0]) b0++;
         if (d_done[1] && d_done[0]) begin
            ok = 1;
            break;
         end
         start = extra && (n == at);
         @(posedge clk); #1;
      end
      start = 0;
      chk("sweep_timeout", 32'(ok), 32'd1);
   endtask

   initial begin
      bit found;
      logic [31:0] good;
      rst_n = 0; start = 0; exp_sig = '0; mode = 0;
      for (int i = 0; i < 256; i++) rtab[i] = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(d_busy[1]), 0);
      chk("rst_done", 32'(d_done[1]), 0);
      chk("rst_sig", d_sig[1], 0);
      chk("rst_cnt", 32'(d_cnt[1]), 0);
      rst_n = 1;
      @(posedge clk); #1;

      // zero responses, extra start while busy must be ignored
      run_sweep(1, 100);
      chk("t1_busy1", b1, 768);
      chk("t1_busy0", b0, 512);
      chk("t1_sig", d_sig[1], 0);
      chk("t1_cnt", 32'(d_cnt[1]), 256);
      chk("t1_pass", 32'(d_pass[1]), 1);
      chk("t1_in_v0", 32'(hist_in[1]), 32'h00);
      chk("t1_in_v16a", 32'(hist_in[49]), 32'h10);
      chk("t1_in_v16b", 32'(hist_in[51]), 32'h10);
      chk("t1_in_v17", 32'(hist_in[52]), 32'h11);
      chk("t1_in_last", 32'(hist_in[766]), 32'hFF);

      exp_sig = 32'd1;
      run_sweep(0, 0);
      chk("t2_pass1", 32'(d_pass[1]), 0);
      chk("t2_pass0", 32'(d_pass[0]), 0);

      mode = 1;
      run_sweep(0, 0);
      chk("t3_sig1", hist_sig[3], 32'h1);
      chk("t3_sig2", hist_sig[6], 32'h3);
      chk("t3_sig3", hist_sig[9], 32'h7);
      chk("t3_pre1", pre[1][1], 32'h1);
      chk("t3_pre3", pre[1][3], 32'h7);
      chk("t3_final", d_sig[1], sweep_sig(1));

      mode = 2;
      good = sweep_sig(2);
      exp_sig = good;
      run_sweep(0, 0);
      chk("t4_clr_sig", hist_sig[0], 0);
      chk("t4_clr_done", 32'(hist_done[0]), 0);
      chk("t4_sig", d_sig[1], good);
      chk("t4_pass1", 32'(d_pass[1]), 1);
      chk("t4_pass0", 32'(d_pass[0]), 1);

      mode = 3;
      run_sweep(0, 0);
      chk("t5_pass1", 32'(d_pass[1]), 0);
      chk("t5_pass0", 32'(d_pass[0]), 0);

      // reset in the middle of a sweep
      mode = 2;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      found = 0;
      for (int n = 0; n < 1000; n++) begin
         if (d_cnt[1] == 9'd100) begin
            found = 1;
            break;
         end
         @(posedge clk); #1;
      end
      chk("t6_reach100", 32'(found), 1);
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      chk("t6_busy", 32'(d_busy[1]), 0);
      chk("t6_sig", d_sig[1], 0);
      chk("t6_cnt", 32'(d_cnt[1]), 0);
      chk("t6_in", 32'(d_in[1]), 0);
      chk("t6_sig0", d_sig[0], 0);
      run_sweep(0, 0);
      chk("t6_busy1", b1, 768);
      chk("t6_pass", 32'(d_pass[1]), 1);

      // random result banks with random stray starts
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 256; i++)
            for (int j = 0; j < 8; j++)
               rtab[i][j*32 +: 32] = (j == 7) ? 32'($urandom() & 32'hFFF)
                                              : 32'($urandom());
         mode = 4;
         good = sweep_sig(4);
         exp_sig = ($urandom_range(0, 1) == 1) ? good : 32'($urandom());
         run_sweep(1, $urandom_range(1, 500));
         chk("t7_sig", d_sig[1], good);
         chk("t7_pass", 32'(d_pass[1]), 32'(exp_sig == good));
         chk("t7_cnt", 32'(d_cnt[0]), 256);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/port_sweep_checker.md
Name: port_sweep_checker

Overview:
- Stimulus-and-response end of the 4-bit operand port-test harness.
- Sweeps every (in1, in2) operand pair into a device under test and captures its flattened bank of 4-bit result ports.
- Compresses the captured results into a 32-bit MISR signature and compares it to an expected signature.
- Sits in the system-test wrapper around the port-connection DUT, on the opposite side of its in1/in2/out* ports.

Parameters:
- WIDTH, 4, operand width of in1/in2 and of each DUT result port.
- NOUT, 59, number of DUT result ports captured (3 + 8*7).
- SETTLE, 1, cycles to wait after driving a vector before capture; legal range 0..15.
- POLY, 32'h04C11DB7, MISR feedback polynomial.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a sweep; ignored unless in IDLE or DONE.
- exp_sig  in  32  expected signature, sampled at sweep end.
- resp  in  NOUT*WIDTH  flattened DUT outputs; port k occupies bits [k*WIDTH +: WIDTH].
- in1  out  WIDTH  operand A to DUT.
- in2  out  WIDTH  operand B to DUT.
- busy  out  1  sweep in progress.
- done  out  1  sweep complete; sticky until next accepted start or reset.
- pass  out  1  sig == exp_sig; valid while done=1, 0 otherwise.
- sig  out  32  current MISR value.
- vec_cnt  out  2*WIDTH+1  number of vectors captured so far.

Behaviour:
- Reset: clk and rst_n are as already decided (one clock; reset synchronous, active-low). When rst_n=0 at a clk edge:
  - state <= IDLE; in1, in2, sig, vec_cnt <= 0; busy, done, pass <= 0.
  - Reset mid-sweep aborts the sweep immediately; no partial signature is retained.
- FSM states IDLE, DRIVE, SETTLE, CAPTURE, DONE:
  - IDLE/DONE + start: clear sig, vec_cnt, vector index v, settle counter, done, pass; go to DRIVE.
  - DRIVE (1 cycle): in1 <= v[WIDTH-1:0], in2 <= v[2*WIDTH-1:WIDTH], both registered. Go to SETTLE if SETTLE>0, else to CAPTURE.
  - SETTLE: count SETTLE cycles, then go to CAPTURE.
  - CAPTURE (1 cycle): update the MISR from resp; vec_cnt++.
    - If v == 2^(2*WIDTH)-1, go to DONE.
    - Otherwise v++ and go to DRIVE.
  - DONE: done=1; pass = (sig == exp_sig), registered on DONE entry.
- busy=1 in DRIVE/SETTLE/CAPTURE.
- in1/in2 hold their values from DRIVE through CAPTURE; after DONE they hold the last vector.
- Timing:
  - Each vector takes 2+SETTLE cycles.
  - Defaults: 256 vectors × 3 = 768 busy cycles.
  - done rises on the cycle after the final CAPTURE.
- MISR:
  - fold = XOR of all 32-bit slices of resp, zero-padded to a multiple of 32 (236 bits → 8 slices).
  - sig_next = (sig << 1) ^ (sig[31] ? POLY : 0) ^ fold. Computed mod 2^32, updated only in CAPTURE.
- vec_cnt is wide enough to hold 2^(2*WIDTH) without wrap; the final value is 256.
- A start received in DONE restarts the sweep; the old sig/pass are cleared on that start edge.
- start and rst_n asserted together: reset wins.
- resp is sampled only in CAPTURE. X/changes on resp in other states have no effect.

Decomposition:
- Package port_sweep_pkg: state enum (IDLE, DRIVE, SETTLE, CAPTURE, DONE) and the default POLY constant.
- One sub-module, misr32: combinational fold of the resp bus plus the registered signature with clear/enable.
- The FSM and counters stay in port_sweep_checker.

Test Plan:
- resp tied to 0, start pulse, defaults:
  - busy for 768 cycles; then done=1, sig=0, vec_cnt=256.
  - pass=1 with exp_sig=0; pass=0 with exp_sig=1.
- Observe in1/in2 across the sweep:
  - First DRIVE gives in1=0, in2=0; 17th vector gives in1=0, in2=1.
  - Final vector gives in1=F, in2=F.
  - Each vector is stable for 3 cycles.
- resp bit0 forced 1, all others 0:
  - sig after captures 1, 2, 3 = 0x1, 0x3, 0x7.
  - Final sig matches the bench MISR model.
- Connect to the reference DUT model's 59 outputs:
  - Final sig equals the model-computed signature; pass=1.
  - Flipping one bit of bout3 at vector 0x5A gives pass=0.
- Reset mid-sweep: rst_n=0 for 1 cycle at vec_cnt=100 gives all outputs 0 and state IDLE; a later start runs the full 768 cycles.
- SETTLE=0 gives 512 busy cycles; start during busy is ignored; start in DONE restarts with sig cleared.
